// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller slice.
// Contents:
//   state_e   - controller FSM states (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN)
//   DIR_*     - encodings driven on the dir output
//   fw_of()   - floor index width for a given floor count (never below 1)
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Width of a binary floor index; a two-floor car still needs one bit.
    function automatic int fw_of(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_ctrl_n_if.sv
// Request/status bundle between a car controller and its user.
// Signals:
//   req_valid, req_floor  - floor request (master -> controller)
//   door_hold             - keep the door open (master -> controller)
//   door, floor, dir      - car status (controller -> master)
//   pending               - outstanding request vector, bit i = floor i
// Modports: master (request side), slave (controller side).
interface elevator_ctrl_n_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 5
);
    localparam int FW = fw_of(NUM_FLOORS);

    logic                  req_valid;
    logic [FW-1:0]         req_floor;
    logic                  door_hold;
    logic                  door;
    logic [FW-1:0]         floor;
    logic [1:0]            dir;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req_valid, req_floor, door_hold,
        input  door, floor, dir, pending
    );

    modport slave (
        input  req_valid, req_floor, door_hold,
        output door, floor, dir, pending
    );

endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_i       - load load_val_i this edge (wins over counting)
//   load_val_i   - value to load
//   done_o       - count has reached zero
module elevator_timer #(
    parameter int  MAX_COUNT = 20,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          done_o
);

    logic [CW-1:0] count_q;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CW'(0);
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != CW'(0)) begin
            count_q <= count_q - CW'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign done_o = (count_q == CW'(0));

endmodule

// File: rtl/elevator_ctrl_n.sv
// Single-car SCAN elevator controller.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - elevator_ctrl_n_if.slave: requests/door_hold in,
//            registered door/floor/dir/pending out
// Travel takes TRAVEL_CYCLES per floor; the door dwells DOOR_CYCLES after
// the last of entry, a repeat request for this floor, or door_hold falling.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 5,
    parameter int TRAVEL_CYCLES = 10,
    parameter int DOOR_CYCLES   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    elevator_ctrl_n_if.slave  bus
);

    localparam int FW   = fw_of(NUM_FLOORS);
    localparam int NF   = NUM_FLOORS;
    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // A timer loaded with N expires N+1 edges later, hence the -1 loads.
    // While door_hold is high the full DOOR_CYCLES is loaded, so the dwell
    // is counted from the first edge that sees door_hold low.
    localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(DOOR_CYCLES);
    localparam logic [FW:0]   NF_L        = (FW + 1)'(NUM_FLOORS);

    state_e         state_q, state_d;
    logic [FW-1:0]  floor_q, floor_d;
    logic [1:0]     dir_q, dir_d;
    logic           door_q, door_d;
    logic [NF-1:0]  pend_q, pend_d;
    logic           last_up_q, last_up_d;

    logic           tmr_load_s;
    logic [CW-1:0]  tmr_val_s;
    logic           tmr_done_s;

    logic           req_ok_s, req_here_s;
    logic [NF-1:0]  req_bit_s, pend_req_s;
    logic [FW-1:0]  arr_floor_s;
    logic           idle_up_s, idle_dn_s, idle_go_up_s;
    logic           cur_up_s, cur_dn_s, exp_go_up_s;
    logic           arr_up_s, arr_dn_s, arr_hit_s;

    function automatic logic [NF-1:0] floor_bit(input logic [FW-1:0] f);
        return NF'(1) << f;
    endfunction

    // Bits strictly above f; shifting past the top wraps to an empty mask.
    function automatic logic [NF-1:0] above_mask(input logic [FW-1:0] f);
        return ~((NF'(2) << f) - NF'(1));
    endfunction

    function automatic logic [NF-1:0] below_mask(input logic [FW-1:0] f);
        return (NF'(1) << f) - NF'(1);
    endfunction

    elevator_timer #(.MAX_COUNT(MAXC)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .done_o     (tmr_done_s)
    );

    assign req_ok_s    = bus.req_valid && ({1'b0, bus.req_floor} < NF_L);
    assign req_bit_s   = req_ok_s ? floor_bit(bus.req_floor) : NF'(0);
    assign req_here_s  = req_ok_s && (bus.req_floor == floor_q);
    assign pend_req_s  = pend_q | req_bit_s;

    // Floor reached when the current travel leg completes.
    assign arr_floor_s = (state_q == MOVE_DOWN) ? (floor_q - FW'(1)) : (floor_q + FW'(1));

    // IDLE decides on the registered vector; a new request waits one edge.
    assign idle_up_s    = |(pend_q & above_mask(floor_q));
    assign idle_dn_s    = |(pend_q & below_mask(floor_q));
    assign idle_go_up_s = idle_up_s && (last_up_q || !idle_dn_s);

    // Dwell expiry and arrival also honour a request landing this cycle.
    assign cur_up_s     = |(pend_req_s & above_mask(floor_q));
    assign cur_dn_s     = |(pend_req_s & below_mask(floor_q));
    assign exp_go_up_s  = cur_up_s && (last_up_q || !cur_dn_s);
    assign arr_up_s     = |(pend_req_s & above_mask(arr_floor_s));
    assign arr_dn_s     = |(pend_req_s & below_mask(arr_floor_s));
    assign arr_hit_s    = |(pend_req_s & floor_bit(arr_floor_s));

    // Next-state, request bookkeeping and timer control.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        door_d     = door_q;
        pend_d     = pend_req_s;
        last_up_d  = last_up_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = TRAVEL_LOAD;
        case (state_q)
            IDLE: begin
                if (req_here_s || (|(pend_q & floor_bit(floor_q)))) begin
                    pend_d     = pend_req_s & ~floor_bit(floor_q);
                    state_d    = DOOR_OPEN;
                    door_d     = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DOOR_LOAD;
                end else if (idle_up_s || idle_dn_s) begin
                    state_d    = idle_go_up_s ? MOVE_UP : MOVE_DOWN;
                    dir_d      = idle_go_up_s ? DIR_UP : DIR_DOWN;
                    last_up_d  = idle_go_up_s;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TRAVEL_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_done_s) begin
                    floor_d = arr_floor_s;
                    if (arr_hit_s) begin
                        pend_d     = pend_req_s & ~floor_bit(arr_floor_s);
                        state_d    = DOOR_OPEN;
                        dir_d      = DIR_IDLE;
                        door_d     = 1'b1;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = DOOR_LOAD;
                    end else if ((state_q == MOVE_UP) ? arr_up_s : arr_dn_s) begin
                        tmr_load_s = 1'b1;
                        tmr_val_s  = TRAVEL_LOAD;
                    end else begin
                        // Reversal goes through IDLE so dir never flips in one step.
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end else begin
                    floor_d = floor_q;
                end
            end
            DOOR_OPEN: begin
                pend_d = req_here_s ? pend_q : pend_req_s;
                if (bus.door_hold) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LOAD;
                end else if (req_here_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DOOR_LOAD;
                end else if (tmr_done_s) begin
                    door_d = 1'b0;
                    if (exp_go_up_s || cur_dn_s) begin
                        state_d    = exp_go_up_s ? MOVE_UP : MOVE_DOWN;
                        dir_d      = exp_go_up_s ? DIR_UP : DIR_DOWN;
                        last_up_d  = exp_go_up_s;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end else begin
                    door_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dir_d   = DIR_IDLE;
                door_d  = 1'b0;
            end
        endcase
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            floor_q   <= FW'(0);
            dir_q     <= DIR_IDLE;
            door_q    <= 1'b0;
            pend_q    <= NF'(0);
            last_up_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            door_q    <= door_d;
            pend_q    <= pend_d;
            last_up_q <= last_up_d;
        end
    end

    assign bus.door    = door_q;
    assign bus.floor   = floor_q;
    assign bus.dir     = dir_q;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n: directed scenarios followed by
// random requests/door_hold/resets, compared every cycle against a
// deadline-based behavioural model of the car.
module tb_elevator_ctrl_n;

    localparam int NF     = 5;
    localparam int TRAVEL = 10;
    localparam int DOOR   = 20;

    logic clk;
    logic rst_n;

    elevator_ctrl_n_if #(.NUM_FLOORS(NF)) bus ();

    elevator_ctrl_n #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {MI, MU, MD, MO} mmode_e;
    mmode_e m_mode;
    int     m_floor, m_dir, m_cyc, m_deadline;
    bit     m_door, m_last_up;
    bit     m_pend[NF];

    function automatic bit any_above(input int f);
        for (int i = f + 1; i < NF; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input int f);
        for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] pend_vec();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = MI; m_floor = 0; m_dir = 0; m_door = 1'b0; m_last_up = 1'b1;
        m_cyc = 0; m_deadline = 0;
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    endtask

    task automatic open_door();
        m_mode = MO; m_door = 1'b1; m_dir = 0; m_deadline = m_cyc + DOOR;
    endtask

    task automatic start_move(input bit up);
        m_mode = up ? MU : MD; m_dir = up ? 1 : 2; m_last_up = up;
        m_deadline = m_cyc + TRAVEL;
    endtask

    // SCAN choice: prefer the last direction, otherwise the other, else rest.
    task automatic choose_dir();
        bit a, b;
        a = any_above(m_floor);
        b = any_below(m_floor);
        if (m_last_up) begin
            if (a) start_move(1'b1);
            else if (b) start_move(1'b0);
            else begin m_mode = MI; m_dir = 0; end
        end else begin
            if (b) start_move(1'b0);
            else if (a) start_move(1'b1);
            else begin m_mode = MI; m_dir = 0; end
        end
    endtask

    task automatic model_step(input bit v, input int rf, input bit h);
        bit inr, here;
        m_cyc++;
        inr  = v && (rf < NF);
        here = inr && (rf == m_floor);
        case (m_mode)
            MI: begin
                if (here || m_pend[m_floor]) begin
                    if (inr && !here) m_pend[rf] = 1'b1;
                    m_pend[m_floor] = 1'b0;
                    open_door();
                end else begin
                    if (any_above(m_floor) || any_below(m_floor)) choose_dir();
                    if (inr) m_pend[rf] = 1'b1;
                end
            end
            MU, MD: begin
                if (inr) m_pend[rf] = 1'b1;
                if (m_cyc == m_deadline) begin
                    m_floor += (m_mode == MU) ? 1 : -1;
                    if (m_pend[m_floor]) begin
                        m_pend[m_floor] = 1'b0;
                        open_door();
                    end else if ((m_mode == MU) ? any_above(m_floor) : any_below(m_floor)) begin
                        m_deadline = m_cyc + TRAVEL;
                    end else begin
                        m_mode = MI; m_dir = 0;
                    end
                end
            end
            default: begin
                if (inr && !here) m_pend[rf] = 1'b1;
                if (h) m_deadline = m_cyc + 1 + DOOR;
                else if (here) m_deadline = m_cyc + DOOR;
                else if (m_cyc == m_deadline) begin
                    m_door = 1'b0;
                    choose_dir();
                end
            end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic compare_all();
        check_val("floor", bus.floor, m_floor);
        check_val("door", bus.door, m_door);
        check_val("dir", bus.dir, m_dir);
        check_val("pending", bus.pending, pend_vec());
        check_val("door_while_moving", bus.door && (bus.dir != 2'b00), 0);
        check_val("floor_range", bus.floor < NF, 1);
    endtask

    task automatic tick(input bit v, input logic [2:0] f, input bit h);
        bus.req_valid = v;
        bus.req_floor = f;
        bus.door_hold = h;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(v, int'(f), h);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 1'b0);
    endtask

    // Asserted away from the clock edge; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick(1'b1, 3'd2, 1'b0);
        tick(1'b1, 3'd4, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int hold_cnt;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_floor = 3'd0;
        bus.door_hold = 1'b0;
        model_reset();
        tick(1'b0, 3'd0, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        check_val("reset_floor", bus.floor, 0);
        check_val("reset_pending", bus.pending, 0);
        rst_n = 1'b1;

        // Single request to floor 3.
        tick(1'b1, 3'd3, 1'b0);
        run(1);
        check_val("r034_dir_up", bus.dir, 2'b01);
        run(10); check_val("r034_floor1", bus.floor, 1);
        run(10); check_val("r034_floor2", bus.floor, 2);
        run(10); check_val("r034_floor3", bus.floor, 3);
        check_val("r034_door", bus.door, 1);
        check_val("r034_pend3", bus.pending[3], 0);

        // Request behind the car is served on the reverse sweep.
        do_reset();
        tick(1'b1, 3'd4, 1'b0);
        run(21);
        check_val("r035_at2", bus.floor, 2);
        tick(1'b1, 3'd1, 1'b0);
        run(19);
        check_val("r035_at4", bus.floor, 4);
        check_val("r035_door4", bus.door, 1);
        run(20);
        check_val("r035_dir_down", bus.dir, 2'b10);
        run(30);
        check_val("r035_at1", bus.floor, 1);
        check_val("r035_door1", bus.door, 1);
        check_val("r035_pend", bus.pending, 0);

        // Current-floor request and door_hold.
        do_reset();
        tick(1'b1, 3'd0, 1'b0);
        check_val("r036_open", bus.door, 1);
        run(19); check_val("r036_still_open", bus.door, 1);
        run(1);  check_val("r036_closed", bus.door, 0);
        tick(1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 50; i++) tick(1'b0, 3'd0, 1'b1);
        check_val("r036_held", bus.door, 1);
        run(20); check_val("r036_dwell_after_hold", bus.door, 1);
        run(1);  check_val("r036_closed_after_hold", bus.door, 0);

        // Out-of-range request ignored.
        do_reset();
        tick(1'b1, 3'd4, 1'b0);
        tick(1'b1, 3'd7, 1'b0);
        check_val("r037_pending", bus.pending, 5'b10000);
        run(80);
        check_val("r037_final_floor", bus.floor, 4);

        // Reset in mid-travel.
        do_reset();
        tick(1'b1, 3'd4, 1'b0);
        run(11);
        tick(1'b1, 3'd0, 1'b0);
        run(19);
        check_val("r038_at3", bus.floor, 3);
        check_val("r038_pend", bus.pending, 5'b10001);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("r038_floor0", bus.floor, 0);
        check_val("r038_dir0", bus.dir, 0);
        check_val("r038_pend0", bus.pending, 0);
        check_val("r038_door0", bus.door, 0);
        tick(1'b1, 3'd3, 1'b0);
        rst_n = 1'b1;
        run(30);
        check_val("r038_idle_dir", bus.dir, 0);
        check_val("r038_idle_floor", bus.floor, 0);

        // Request for the arrival floor in the arrival cycle.
        do_reset();
        tick(1'b1, 3'd3, 1'b0);
        run(20);
        tick(1'b1, 3'd2, 1'b0);
        check_val("r039_floor", bus.floor, 2);
        check_val("r039_door", bus.door, 1);
        check_val("r039_pend", bus.pending, 5'b01000);

        // Random traffic.
        do_reset();
        hold_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            bit v, h;
            logic [2:0] f;
            v = ($urandom_range(0, 9) == 0);
            f = 3'($urandom_range(0, 7));
            if (hold_cnt > 0) begin
                hold_cnt--;
                h = 1'b1;
            end else begin
                h = 1'b0;
                if ($urandom_range(0, 149) == 0) hold_cnt = $urandom_range(1, 40);
            end
            tick(v, f, h);
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 Parameter NUM_FLOORS, default 5, number of floors served (2..64).
REQ-002 Parameter TRAVEL_CYCLES, default 10, clock cycles to move one floor (>=1).
REQ-003 Parameter DOOR_CYCLES, default 20, clock cycles the door dwells open (>=1).
REQ-004 Derived constant FW = clog2(NUM_FLOORS), minimum 1; FW is not a user parameter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  a floor request is presented this cycle.
REQ-008 req_floor  input  FW  requested floor, binary, 0-based.
REQ-009 door_hold  input  1  keep door open; restarts dwell while high.
REQ-010 door  output  1  1 = door open, 0 = closed.
REQ-011 floor  output  FW  current floor, binary.
REQ-012 dir  output  2  01 up, 10 down, 00 stationary; 11 never driven.
REQ-013 pending  output  NUM_FLOORS  registered outstanding-request vector, bit i = floor i.

Function
REQ-014 The FSM SHALL have states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; dir = 01 only in MOVE_UP, 10 only in MOVE_DOWN, else 00.
REQ-015 A request with req_floor >= NUM_FLOORS SHALL be ignored.
REQ-016 A valid request SHALL set pending[req_floor] at the next edge, except as in REQ-017/018.
REQ-017 A request for the current floor in IDLE SHALL not set pending; DOOR_OPEN is entered on the next edge (door = 1 one cycle after req_valid).
REQ-018 A request for the current floor in DOOR_OPEN SHALL restart the dwell counter and not set pending.
REQ-019 In IDLE with pending nonzero, the controller SHALL enter MOVE_UP if any pending bit is above floor, else MOVE_DOWN; when both sides are pending, the last travelled direction SHALL be kept (up after reset).
REQ-020 In MOVE_UP/MOVE_DOWN, floor SHALL change by exactly +1/-1 every TRAVEL_CYCLES cycles; floor never leaves 0..NUM_FLOORS-1.
REQ-021 On arrival at floor f with pending[f] = 1 (including a bit set by a request in the arrival cycle), the controller SHALL clear pending[f] and enter DOOR_OPEN.
REQ-022 On arrival with pending[f] = 0, travel SHALL continue in the same direction if a pending bit lies beyond f, otherwise reverse if any pending remains, otherwise enter IDLE.
REQ-023 A request for a floor already passed SHALL stay pending and be served on the reverse sweep (SCAN order).
REQ-024 DOOR_OPEN SHALL last DOOR_CYCLES cycles after the last of: entry, door_hold low edge, REQ-018 restart; while door_hold = 1 the door SHALL stay open.
REQ-025 On dwell expiry the next state SHALL be chosen per REQ-022 rules from the current floor.
REQ-026 The door SHALL never be open while dir != 00, and dir SHALL never change without passing through DOOR_OPEN or IDLE.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_n = 0: state IDLE, floor = 0, door = 0, dir = 00, pending = 0, timers = 0, last direction = up.
REQ-029 Reset asserted mid-travel or mid-dwell SHALL discard all pending requests and return immediately to REQ-028 values; requests during reset are ignored.
REQ-030 Operation SHALL resume on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package elevator_pkg SHALL hold the state enum and the dir encodings DIR_IDLE, DIR_UP, DIR_DOWN.
REQ-032 One sub-module, elevator_timer (loadable down-counter with done flag, width from its max count), SHALL be instanced for travel and dwell timing.
REQ-033 Request-beyond-floor detection SHALL be combinational masks over pending, with no per-floor FSMs.

Verification
REQ-034 Reset, req floor 3 (NUM_FLOORS=5, TRAVEL=10) -> dir=01, floor 1,2,3 at +10,+20,+30 cycles, door=1 at floor 3, pending[3] cleared.
REQ-035 At floor 2 moving up to 4, req floor 1 -> stops at 4, dwells 20 cycles, then dir=10, stops at 1.
REQ-036 Idle at 0, req floor 0 -> door=1 next cycle, door=0 after 20 cycles; door_hold high 50 cycles -> door stays 1 until 20 cycles after hold falls.
REQ-037 Requests floor 4 and 7 (out of range) in same burst -> only pending[4] set; floor stays within 0..4 throughout.
REQ-038 rst_n pulsed low while moving at floor 3 with pending 0b10001 -> floor=0, door=0, dir=00, pending=0 asynchronously, controller stays IDLE after release.
REQ-039 Request for floor 2 arriving in the same cycle the car reaches floor 2 -> door opens at 2, pending[2] remains 0.
